pwm_multi_ctrl: RTL and testbench

Parametrised multi-channel PWM generator with button-driven duty adjustment. It runs from a single system clock and replaces per-button clock domains with synchronised, debounced press pulses. Duty changes are double-buffered through shadow registers and take effect only at a period boundary. Supports edge-aligned and center-aligned modes. Sits between the board buttons and the PWM pins and display logic.

---
 rtl/pwm_multi_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pwm_multi_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator driven by debounced push-buttons on one clock.
// Duty edits land in shadow registers and load into the active set at each period boundary.
`timescale 1ns/1ps
module pwm_multi_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int PERIOD      = 100,
  parameter int PRESC       = 1,
  parameter int FINE_STEP   = 1,
  parameter int COARSE_STEP = 5,
  parameter int DEBOUNCE    = 50000,
  parameter int INIT_DUTY   = 0,
  localparam int DW = $clog2(PERIOD + 1),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_f_n,
  input  logic                inc_c_n,
  input  logic                dec_f_n,
  input  logic                dec_c_n,
  input  logic [CW-1:0]       ch_sel,
  input  logic                center,
  output logic [CHANNELS-1:0] pwm,
  output logic [DW-1:0]       duty_sel,
  output logic                period_tick
);

  localparam int SW  = DW + 2;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [DW-1:0]        CNT_LAST   = DW'(PERIOD - 1);
  localparam logic [DW-1:0]        DUTY_MAX   = DW'(PERIOD);
  localparam logic [DW-1:0]        DUTY_INIT  = DW'(INIT_DUTY);
  localparam logic [DBW-1:0]       DB_LAST    = DBW'(DEBOUNCE - 1);
  localparam logic [PW-1:0]        PRESC_LAST = PW'(PRESC - 1);
  localparam logic signed [SW-1:0] FINE_S     = SW'(FINE_STEP);
  localparam logic signed [SW-1:0] COARSE_S   = SW'(COARSE_STEP);
  localparam logic signed [SW-1:0] MAX_S      = $signed({2'b00, DUTY_MAX});

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Button lanes: 0 inc_f, 1 inc_c, 2 dec_f, 3 dec_c
  localparam int B_INC_F = 0;
  localparam int B_INC_C = 1;
  localparam int B_DEC_F = 2;
  localparam int B_DEC_C = 3;

  logic [3:0]           btn_raw;
  logic [3:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]           db_state_q, db_state_d;
  logic [DBW-1:0]       db_cnt_q [4];
  logic [DBW-1:0]       db_cnt_d [4];
  logic [3:0]           press_q, press_d;

  logic [PW-1:0]        presc_q, presc_d;
  logic                 en;
  logic                 boundary;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 mode_q, mode_d;
  logic                 tick_q, tick_d;

  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] sum [CHANNELS];
  logic [DW-1:0]        shadow_q [CHANNELS];
  logic [DW-1:0]        shadow_d [CHANNELS];
  logic [DW-1:0]        active_q [CHANNELS];
  logic [DW-1:0]        active_d [CHANNELS];
  logic [CHANNELS-1:0]  pwm_q, pwm_d;

  assign btn_raw = {dec_c_n, dec_f_n, inc_c_n, inc_f_n};

  // A lane flips only after DEBOUNCE consecutive clocks of disagreement.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    db_state_d = db_state_q;
    for (int b = 0; b < 4; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != db_state_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          db_state_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
    press_d = db_state_q & ~db_state_d;
  end

  always_comb begin
    delta = '0;
    if (press_q[B_INC_C]) delta = delta + COARSE_S;
    if (press_q[B_INC_F]) delta = delta + FINE_S;
    if (press_q[B_DEC_C]) delta = delta - COARSE_S;
    if (press_q[B_DEC_F]) delta = delta - FINE_S;
  end

  // Saturating update of the selected shadow; an unmatched ch_sel selects nothing.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      sum[i]      = $signed({2'b00, shadow_q[i]}) + delta;
      if ((ch_sel == CW'(i)) && (|press_q)) begin
        if (sum[i] < 0) begin
          shadow_d[i] = '0;
        end else if (sum[i] > MAX_S) begin
          shadow_d[i] = DUTY_MAX;
        end else begin
          shadow_d[i] = sum[i][DW-1:0];
        end
      end
    end
  end

  always_comb begin
    en       = (presc_q == PRESC_LAST);
    presc_d  = en ? '0 : presc_q + 1'b1;
    boundary = en && (mode_q ? ((cnt_q == '0) && (dir_q == DIR_DOWN))
                             : (cnt_q == CNT_LAST));
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    tick_d   = boundary;
    if (boundary) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      mode_d = center;
    end else if (en) begin
      if (!mode_q) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dir_q == DIR_UP) begin
        // The top value is held for one extra step while turning around.
        if (cnt_q == CNT_LAST) dir_d = DIR_DOWN;
        else                   cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Compare against next-state values so duty and counter change in the same clock.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_d[i] = boundary ? shadow_q[i] : active_q[i];
      pwm_d[i]    = (cnt_d < active_d[i]);
    end
  end

  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CW'(i)) duty_sel = shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      db_state_q <= '1;
      press_q    <= '0;
      for (int b = 0; b < 4; b++) db_cnt_q[b] <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      mode_q     <= 1'b0;
      tick_q     <= 1'b0;
      pwm_q      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= DUTY_INIT;
        active_q[i] <= DUTY_INIT;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_state_q <= db_state_d;
      press_q    <= press_d;
      for (int b = 0; b < 4; b++) db_cnt_q[b] <= db_cnt_d[b];
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
      pwm_q      <= pwm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench: u_dut is edge-aligned with PRESC=1, u_ctr (3 channels, PRESC=2)
// covers center-aligned timing and out-of-range channel selects.
`timescale 1ns/1ps
module tb_pwm_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_a, btn_b;   // [0] inc_f, [1] inc_c, [2] dec_f, [3] dec_c
  logic [1:0] sel_a, sel_b;
  logic       center_a, center_b;
  logic [3:0] pwm_a;
  logic [2:0] pwm_b;
  logic [6:0] duty_a, duty_b;
  logic       tick_a, tick_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multi_ctrl #(
    .CHANNELS(4), .PERIOD(100), .PRESC(1), .FINE_STEP(1), .COARSE_STEP(5),
    .DEBOUNCE(4), .INIT_DUTY(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .inc_f_n(btn_a[0]), .inc_c_n(btn_a[1]), .dec_f_n(btn_a[2]), .dec_c_n(btn_a[3]),
    .ch_sel(sel_a), .center(center_a),
    .pwm(pwm_a), .duty_sel(duty_a), .period_tick(tick_a)
  );

  pwm_multi_ctrl #(
    .CHANNELS(3), .PERIOD(100), .PRESC(2), .FINE_STEP(1), .COARSE_STEP(5),
    .DEBOUNCE(4), .INIT_DUTY(0)
  ) u_ctr (
    .clk(clk), .rst_n(rst_n),
    .inc_f_n(btn_b[0]), .inc_c_n(btn_b[1]), .dec_f_n(btn_b[2]), .dec_c_n(btn_b[3]),
    .ch_sel(sel_b), .center(center_b),
    .pwm(pwm_b), .duty_sel(duty_b), .period_tick(tick_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the masked buttons low long enough to register, then release fully.
  task automatic press(input bit which, input logic [3:0] mask);
    if (which) btn_b = ~mask; else btn_a = ~mask;
    step(10);
    btn_a = 4'hF;
    btn_b = 4'hF;
    step(10);
  endtask

  task automatic wait_tick(input bit which, output int n);
    logic t;
    n = 0;
    do begin
      step(1);
      n++;
      t = which ? tick_b : tick_a;
    end while (!t && n < 1000);
    chk(which ? "tick_b_seen" : "tick_a_seen", int'(t), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cnt_hi, cnt_lo, h1, h2, ticks;
    rst_n = 1'b0; btn_a = 4'hF; btn_b = 4'hF;
    sel_a = 2'd0; sel_b = 2'd0; center_a = 1'b0; center_b = 1'b0;
    step(3);
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_duty", int'(duty_a), 0);
    chk("rst_tick", int'(tick_a), 0);
    rst_n = 1'b1;

    wait_tick(0, n); chk("tick_first", n, 100);
    wait_tick(0, n); chk("tick_period", n, 100);

    // 3-clock glitch is rejected; a held press lands DEBOUNCE+3 clocks later
    btn_a[0] = 1'b0; step(3); btn_a[0] = 1'b1; step(12);
    chk("glitch_reject", int'(duty_a), 0);
    btn_a[0] = 1'b0; step(6);
    chk("deb_early", int'(duty_a), 0);
    step(1);
    chk("deb_latency", int'(duty_a), 1);
    step(3); btn_a[0] = 1'b1; step(10);
    chk("release_nopulse", int'(duty_a), 1);

    // ch0 saturation at PERIOD and full-high output
    repeat (20) press(0, 4'b0010);
    chk("sat_high", int'(duty_a), 100);
    wait_tick(0, n);
    cnt_lo = 0;
    for (int k = 0; k < 150; k++) begin
      if (!pwm_a[0]) cnt_lo++;
      step(1);
    end
    chk("full_high_lows", cnt_lo, 0);
    press(0, 4'b1000);
    chk("dec_coarse", int'(duty_a), 95);
    press(0, 4'b0101);
    chk("fine_cancel", int'(duty_a), 95);

    // ch1 floor at 0
    sel_a = 2'd1;
    press(0, 4'b0100);
    chk("floor_zero", int'(duty_a), 0);
    cnt_hi = 0;
    for (int k = 0; k < 120; k++) begin
      if (pwm_a[1]) cnt_hi++;
      step(1);
    end
    chk("zero_duty_highs", cnt_hi, 0);

    // ch2: 25 active, write 30 mid-period, new value only after the boundary
    sel_a = 2'd2;
    repeat (5) press(0, 4'b0010);
    chk("ch2_shadow25", int'(duty_a), 25);
    wait_tick(0, n);
    cnt_hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (pwm_a[2]) cnt_hi++;
      if (k == 43) btn_a[1] = 1'b0;
      if (k == 50) chk("mid_write", int'(duty_a), 30);
      if (k == 53) btn_a[1] = 1'b1;
      step(1);
    end
    chk("old_duty_highs", cnt_hi, 25);
    chk("boundary_tick", int'(tick_a), 1);
    cnt_hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (pwm_a[2]) cnt_hi++;
      step(1);
    end
    chk("new_duty_highs", cnt_hi, 30);

    // u_ctr: ch_sel beyond CHANNELS ignores presses and reads 0
    sel_b = 2'd3;
    press(1, 4'b0010);
    chk("oor_duty_sel", int'(duty_b), 0);
    for (int c = 0; c < 3; c++) begin
      sel_b = 2'(c);
      #1;
      chk($sformatf("oor_ch%0d_untouched", c), int'(duty_b), 0);
    end

    // u_ctr center mode, duty 25, PRESC=2
    sel_b = 2'd0;
    repeat (5) press(1, 4'b0010);
    chk("ctr_shadow25", int'(duty_b), 25);
    center_b = 1'b1;
    wait_tick(1, n);
    h1 = 0; h2 = 0; ticks = 0;
    for (int k = 0; k < 400; k++) begin
      if (pwm_b[0]) begin
        if (k < 200) h1++; else h2++;
      end
      if (k > 0 && tick_b) ticks++;
      if (k == 49)  chk("ctr_k49_high", int'(pwm_b[0]), 1);
      if (k == 50)  chk("ctr_k50_low", int'(pwm_b[0]), 0);
      if (k == 349) chk("ctr_k349_low", int'(pwm_b[0]), 0);
      if (k == 350) chk("ctr_k350_high", int'(pwm_b[0]), 1);
      step(1);
    end
    chk("ctr_period_tick", int'(tick_b), 1);
    chk("ctr_no_early_tick", ticks, 0);
    chk("ctr_high_first_half", h1, 50);
    chk("ctr_high_second_half", h2, 50);

    // asynchronous reset mid-period
    wait_tick(0, n);
    step(10);
    chk("pre_rst_pwm", int'(pwm_a), 5);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_a), 0);
    chk("async_rst_cnt", int'(u_dut.cnt_q), 0);
    chk("async_rst_duty", int'(duty_a), 0);
    step(2);
    rst_n = 1'b1;
    cnt_hi = 0;
    for (int k = 0; k < 150; k++) begin
      if (pwm_a != 4'd0) cnt_hi++;
      step(1);
    end
    chk("post_rst_low", cnt_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
